rns_mac_ctrl: RTL and testbench
===============================

// Module: rns_mac_ctrl
// PURPOSE
//   Sequencer for one shared set-3 RNS multiplier (moduli 2^(N+1)-1, 2^N, 2^N-1).
//   Takes a burst of LEN operand pairs over valid/ready, multiplies each pair per channel,
//   and accumulates the products modulo each channel. Returns one residue triple per burst.
//   Sits between the layer buffer and the residue-to-binary stage of the Res-DNN MAC array.
// PARAMETERS
//   N   4   residue width base: ch1 N+1 bits (mod 2^(N+1)-1), ch2 N bits (mod 2^N), ch3 N bits (mod 2^N-1)
//   LW  8   burst-length counter width; max burst = 2^LW-1 pairs
// PORTS
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous reset, active-high
//   start      in   1    begin burst; sampled only in IDLE
//   len        in   LW   pairs in burst; sampled with start
//   in_valid   in   1    operand pair valid
//   in_ready   out  1    pair accepted when in_valid & in_ready
//   a1,b1      in   N+1  channel-1 operands, each < 2^(N+1)-1
//   a2,b2      in   N    channel-2 operands
//   a3,b3      in   N    channel-3 operands, each < 2^N-1
//   out_valid  out  1    result triple valid; held until out_ready
//   out_ready  in   1    result consumed when out_valid & out_ready
//   acc1       out  N+1  channel-1 accumulated residue, canonical (0..2^(N+1)-2)
//   acc2       out  N    channel-2 accumulated residue
//   acc3       out  N    channel-3 accumulated residue, canonical (0..2^N-2)
//   busy       out  1    high in every state except IDLE
// BEHAVIOUR
//   - Reset: state=IDLE; in_ready=0, out_valid=0, busy=0, acc1/2/3=0, count=0, pipe valid=0.
//   - FSM states IDLE, RUN, DRAIN, DONE:
//     IDLE : start & len!=0 -> RUN. Load count=len. Clear accumulators.
//            start & len==0 -> DONE with acc=0. No pair is accepted.
//     RUN  : in_ready = (count!=0). On each accept, count-- and the product enters the accumulate path.
//            The accept that takes count to 0 -> DRAIN if RNS_MAC_PIPE_EN, else -> DONE.
//     DRAIN: the last product is folded into the accumulators -> DONE (1 cycle).
//     DONE : out_valid=1. acc1..3 stay stable. out_valid & out_ready -> IDLE.
//            A start in the same cycle is ignored; it must be presented again in IDLE.
//   - start is ignored outside IDLE. in_valid outside RUN is ignored (in_ready=0).
//   - Multiply: ch1 and ch3 use the end-around-carry 2^k-1 modular multiply. ch2 keeps the low N bits.
//   - Accumulate per channel:
//     ch2: acc = (acc + p) mod 2^N, carry dropped.
//     ch1/ch3: end-around-carry add, acc = acc + p + cout.
//   - All-ones (the alternate zero) is mapped to 0 before acc1/acc3 are registered.
//     Outputs are therefore always canonical.
//   - Latency, last accept at cycle t: out_valid at t+1 (t+2 with RNS_MAC_PIPE_EN).
//   - in_valid gaps (bubbles) inside RUN stall the burst with no state change and no limit.
//   - Asynchronous reset mid-burst aborts it. All state returns to reset values; a partial result is never output.
// CONFIGURATION
//   RNS_MAC_PIPE_EN defined: a register stage (products + valid bit) sits between the multiplier and the accumulators.
//     Adds 1 cycle of latency and the DRAIN state. Throughput stays 1 pair/cycle.
//   RNS_MAC_PIPE_EN undefined: the multiplier output feeds the accumulators directly.
//     The DRAIN state is never entered. Shorter latency, longer combinational path.
// TESTING  (N=4: moduli 31,16,15; run every test both with and without RNS_MAC_PIPE_EN)
//   1. Reset and idle.
//      Assert rst mid-cycle -> all outputs 0 immediately.
//      in_valid=1 in IDLE -> in_ready stays 0.
//   2. Single pair.
//      Burst len=1, a=(3,5,7), b=(10,3,4) -> acc=(30,15,13).
//      out_valid at t+1 (t+2 with pipe).
//   3. Wrap to zero.
//      Burst len=2: pair 1 as in test 2, pair 2 a=(2,2,2), b=(1,1,1) -> acc=(1,1,0).
//      acc3 must be 0, never 15.
//   4. Back-pressure and bubbles.
//      len=3 with in_valid gaps and out_ready held low 5 cycles -> out_valid and acc stable for all 5 cycles.
//      Then -> IDLE one cycle after out_ready.
//   5. Zero-length burst.
//      start with len=0 -> DONE next cycle, acc=(0,0,0), no pair accepted.
//   6. Abort.
//      rst asserted after 2 of 4 pairs. Then a new burst len=1, a=b=(1,1,1) -> acc=(1,1,1).
//      No residue from the aborted burst.

Source files
------------

// File: rtl/rns_mac_ctrl.sv
// Burst sequencer for a shared set-3 RNS multiply-accumulate (moduli 2^(N+1)-1, 2^N, 2^N-1).
// Define RNS_MAC_PIPE_EN to register the products ahead of the accumulators (adds DRAIN state).
module rns_mac_ctrl #(
    parameter int N  = 4,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N:0]    a1,
    input  logic [N:0]    b1,
    input  logic [N-1:0]  a2,
    input  logic [N-1:0]  b2,
    input  logic [N-1:0]  a3,
    input  logic [N-1:0]  b3,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N:0]    acc1,
    output logic [N-1:0]  acc2,
    output logic [N-1:0]  acc3,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // valid never waits on ready, and out_valid holds with stable data until out_ready.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

`ifdef RNS_MAC_PIPE_EN
    localparam bit PIPE_EN = 1'b1;
`else
    localparam bit PIPE_EN = 1'b0;
`endif

    localparam logic [LW-1:0] ONE = LW'(1);

    state_t        state;
    logic [LW-1:0] count;
    logic          accept;

    // Products straight from the multiplier.
    logic [N:0]    p1;
    logic [N-1:0]  p2;
    logic [N-1:0]  p3;

    // Products as seen by the accumulators, with their qualifier.
    logic [N:0]    f1;
    logic [N-1:0]  f2;
    logic [N-1:0]  f3;
    logic          fv;

    // (a*b) mod 2^(N+1)-1: fold the high half onto the low half with end-around carry.
    function automatic logic [N:0] mul_m1(input logic [N:0] x, input logic [N:0] y);
        logic [2*N+1:0] p;
        logic [N+1:0]   s;
        p = {{(N+1){1'b0}}, x} * {{(N+1){1'b0}}, y};
        s = {1'b0, p[N:0]} + {1'b0, p[2*N+1:N+1]};
        return s[N:0] + {{N{1'b0}}, s[N+1]};
    endfunction

    function automatic logic [N-1:0] mul_m2(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [2*N-1:0] p;
        p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
        return p[N-1:0];
    endfunction

    function automatic logic [N-1:0] mul_m3(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [2*N-1:0] p;
        logic [N:0]     s;
        p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
        s = {1'b0, p[N-1:0]} + {1'b0, p[2*N-1:N]};
        return s[N-1:0] + {{(N-1){1'b0}}, s[N]};
    endfunction

    // End-around-carry add; the all-ones alternate zero is folded to 0 so results stay canonical.
    function automatic logic [N:0] add_m1(input logic [N:0] x, input logic [N:0] y);
        logic [N+1:0] s;
        logic [N:0]   r;
        s = {1'b0, x} + {1'b0, y};
        r = s[N:0] + {{N{1'b0}}, s[N+1]};
        return (r == {(N+1){1'b1}}) ? {(N+1){1'b0}} : r;
    endfunction

    function automatic logic [N-1:0] add_m3(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N:0]   s;
        logic [N-1:0] r;
        s = {1'b0, x} + {1'b0, y};
        r = s[N-1:0] + {{(N-1){1'b0}}, s[N]};
        return (r == {N{1'b1}}) ? {N{1'b0}} : r;
    endfunction

    assign accept = in_valid & in_ready;

    always_comb begin
        p1 = mul_m1(a1, b1);
        p2 = mul_m2(a2, b2);
        p3 = mul_m3(a3, b3);
    end

`ifdef RNS_MAC_PIPE_EN
    logic [N:0]   p1_q;
    logic [N-1:0] p2_q;
    logic [N-1:0] p3_q;
    logic         pv_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_q <= '0;
            p2_q <= '0;
            p3_q <= '0;
            pv_q <= 1'b0;
        end else begin
            pv_q <= accept;
            if (accept) begin
                p1_q <= p1;
                p2_q <= p2;
                p3_q <= p3;
            end
        end
    end

    assign f1 = p1_q;
    assign f2 = p2_q;
    assign f3 = p3_q;
    assign fv = pv_q;
`else
    assign f1 = p1;
    assign f2 = p2;
    assign f3 = p3;
    assign fv = accept;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            acc1      <= '0;
            acc2      <= '0;
            acc3      <= '0;
        end else begin
            // Only RUN and DRAIN ever see fv high, so folding here is safe for all states.
            if (fv) begin
                acc1 <= add_m1(acc1, f1);
                acc2 <= acc2 + f2;
                acc3 <= add_m3(acc3, f3);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        acc1 <= '0;
                        acc2 <= '0;
                        acc3 <= '0;
                        busy <= 1'b1;
                        if (len != '0) begin
                            state    <= RUN;
                            count    <= len;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        count <= count - ONE;
                        if (count == ONE) begin
                            in_ready  <= 1'b0;
                            state     <= PIPE_EN ? DRAIN : DONE;
                            out_valid <= !PIPE_EN;
                        end
                    end
                end
                DRAIN: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_rns_mac_ctrl.sv
// Directed bench for rns_mac_ctrl (N=4: moduli 31, 16, 15); works with or without RNS_MAC_PIPE_EN.
module tb_rns_mac_ctrl;

    localparam int N  = 4;
    localparam int LW = 8;
    localparam int W  = 3 * N + 1;
`ifdef RNS_MAC_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic          in_valid;
    logic          in_ready;
    logic [N:0]    a1, b1;
    logic [N-1:0]  a2, b2, a3, b3;
    logic          out_valid;
    logic          out_ready;
    logic [N:0]    acc1;
    logic [N-1:0]  acc2, acc3;
    logic          busy;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    rns_mac_ctrl #(.N(N), .LW(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready),
        .a1(a1), .b1(b1), .a2(a2), .b2(b2), .a3(a3), .b3(b3),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc1(acc1), .acc2(acc2), .acc3(acc3),
        .busy(busy), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drivers: called and returning at a falling edge.
    task automatic start_burst(input logic [LW-1:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [N:0] x1, input logic [N:0] y1,
                             input logic [N-1:0] x2, input logic [N-1:0] y2,
                             input logic [N-1:0] x3, input logic [N-1:0] y3);
        int g;
        g  = 0;
        a1 = x1; b1 = y1; a2 = x2; b2 = y2; a3 = x3; b3 = y3;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && g < 16) begin
            @(negedge clk);
            g++;
        end
        check("accept_wait", 32'(g < 16), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Scoreboard: compare the result triple against the queue head, hold, then release.
    task automatic finish_burst(input int hold, input logic with_start);
        logic [W-1:0] e;
        int g;
        g = 0;
        while (out_valid !== 1'b1 && g < 16) begin
            @(negedge clk);
            g++;
        end
        check("out_valid_wait", 32'(out_valid), 32'd1);
        e = exp_q.pop_front();
        check("acc", 32'({acc1, acc2, acc3}), 32'(e));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_acc", 32'({acc1, acc2, acc3}), 32'(e));
        end
        out_ready = 1'b1;
        start     = with_start;
        len       = 8'd1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check("release_busy", 32'(busy), 32'd0);
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_state", 32'(dbg_state), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b0;
        a1 = '0; b1 = '0; a2 = '0; b2 = '0; a3 = '0; b3 = '0;
        #3;
        check("rst_outputs", 32'({in_ready, out_valid, busy, acc1, acc2, acc3}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle: in_valid alone never raises in_ready.
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", 32'(in_ready), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
        in_valid = 1'b0;

        // Single pair: 3*10=30 mod 31, 5*3=15 mod 16, 7*4=28 mod 15=13. start during release is ignored.
        start_burst(8'd1);
        check("run_busy", 32'(busy), 32'd1);
        exp_q.push_back({5'd30, 4'd15, 4'd13});
        send_pair(5'd3, 5'd10, 4'd5, 4'd3, 4'd7, 4'd4);
        check("last_in_ready", 32'(in_ready), 32'd0);
        check("latency_first", 32'(out_valid), 32'(LAT == 1));
        @(negedge clk);
        check("latency_second", 32'(out_valid), 32'd1);
        finish_burst(0, 1'b1);

        // Wrap to zero: (30,15,13)+(2,2,2) = (1,1,0); acc3 must not read 15.
        start_burst(8'd2);
        exp_q.push_back({5'd1, 4'd1, 4'd0});
        send_pair(5'd3, 5'd10, 4'd5, 4'd3, 4'd7, 4'd4);
        send_pair(5'd2, 5'd1, 4'd2, 4'd1, 4'd2, 4'd1);
        finish_burst(0, 1'b0);

        // Bubbles and back-pressure: products (1,1,1),(30,10,11),(1,8,0) -> (1,3,12).
        start_burst(8'd3);
        exp_q.push_back({5'd1, 4'd3, 4'd12});
        send_pair(5'd30, 5'd30, 4'd15, 4'd15, 4'd14, 4'd14);
        repeat (2) begin
            @(negedge clk);
            check("bubble_busy", 32'(busy), 32'd1);
            check("bubble_in_ready", 32'(in_ready), 32'd1);
        end
        send_pair(5'd5, 5'd6, 4'd6, 4'd7, 4'd7, 4'd8);
        @(negedge clk);
        send_pair(5'd16, 5'd2, 4'd8, 4'd3, 4'd9, 4'd10);
        finish_burst(5, 1'b0);

        // Zero-length burst straight to DONE with cleared accumulators, no accept.
        in_valid = 1'b1;
        a1 = 5'd7; b1 = 5'd7; a2 = 4'd7; b2 = 4'd7; a3 = 4'd7; b3 = 4'd7;
        start_burst(8'd0);
        check("zero_len_done", 32'(out_valid), 32'd1);
        check("zero_len_in_ready", 32'(in_ready), 32'd0);
        exp_q.push_back({5'd0, 4'd0, 4'd0});
        finish_burst(0, 1'b0);
        in_valid = 1'b0;

        // Abort after 2 of 4 pairs, then a fresh burst must carry no residue.
        start_burst(8'd4);
        send_pair(5'd3, 5'd10, 4'd5, 4'd3, 4'd7, 4'd4);
        send_pair(5'd2, 5'd3, 4'd2, 4'd3, 4'd2, 4'd3);
        #2;
        rst = 1'b1;
        #1;
        check("abort_outputs", 32'({in_ready, out_valid, busy, acc1, acc2, acc3}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start_burst(8'd1);
        exp_q.push_back({5'd1, 4'd1, 4'd1});
        send_pair(5'd1, 5'd1, 4'd1, 4'd1, 4'd1, 4'd1);
        finish_burst(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
